fetch_stage: RTL and testbench

//  Instruction-fetch stage. Owns the program counter and drives the word address into the

---
 rtl/fetch_pkg.sv | 8 +
 rtl/fetch_pc_reg.sv | 39 +++
 rtl/fetch_stage.sv | 92 +++++++++
 tb/tb_fetch_stage.sv | 162 ++++++++++++++++
 4 files changed

// File: rtl/fetch_pkg.sv
// Shared constants for the instruction-fetch stage.
package fetch_pkg;

    localparam int unsigned INSTR_W = 32;
    localparam int unsigned PC_INC = 4;
    localparam logic [INSTR_W-1:0] NOP_INSTR = 32'h0000_0013;

endpackage

// File: rtl/fetch_pc_reg.sv
// Program counter register with next-PC selection (reset > redirect > stall > +4).
module fetch_pc_reg
    import fetch_pkg::*;
#(
    parameter int unsigned       PC_W     = 8,
    parameter logic [PC_W-1:0]   RESET_PC = '0
) (
    input  logic            i_clk,
    input  logic            i_reset,
    input  logic            i_stall,
    input  logic            i_redirect,
    input  logic [PC_W-3:0] i_redirect_word,
    output logic [PC_W-1:0] o_pc
);

    logic [PC_W-1:0] r_pc;
    logic [PC_W-1:0] w_pc_next;

    // The PC is kept word aligned; carry out of the top bit is dropped so it wraps.
    always_comb begin
        w_pc_next = r_pc + PC_W'(PC_INC);
        if (i_redirect) begin
            w_pc_next = {i_redirect_word, 2'b00};
        end else if (i_stall) begin
            w_pc_next = r_pc;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_pc <= {RESET_PC[PC_W-1:2], 2'b00};
        end else begin
            r_pc <= w_pc_next;
        end
    end

    assign o_pc = r_pc;

endmodule

// File: rtl/fetch_stage.sv
// Instruction-fetch stage: PC, IF/ID pipeline register, fetch counter, misalign flag.
// Optional feature: define FETCH_MISALIGN_CHK_EN to flag redirects to unaligned targets.
module fetch_stage
    import fetch_pkg::*;
#(
    parameter int unsigned     PC_W     = 8,
    parameter logic [PC_W-1:0] RESET_PC = '0,
    parameter int unsigned     CNT_W    = 16
) (
    input  logic               i_clk,
    input  logic               i_reset,
    input  logic               i_stall,
    input  logic               i_redirect,
    input  logic [PC_W-1:0]    i_redirect_pc,
    output logic [PC_W-1:0]    o_imem_addr,
    input  logic [INSTR_W-1:0] i_imem_instr,
    output logic [PC_W-1:0]    o_if_pc,
    output logic [PC_W-1:0]    o_if_pc_plus4,
    output logic [INSTR_W-1:0] o_if_instr,
    output logic               o_if_valid,
    output logic [CNT_W-1:0]   o_fetch_count,
    output logic               o_misalign_err
);

    logic [PC_W-1:0]    w_pc;
    logic [PC_W-1:0]    r_if_pc;
    logic [PC_W-1:0]    r_if_pc_plus4;
    logic [INSTR_W-1:0] r_if_instr;
    logic               r_if_valid;
    logic [CNT_W-1:0]   r_fetch_count;

    fetch_pc_reg #(
        .PC_W     (PC_W),
        .RESET_PC (RESET_PC)
    ) u_pc_reg (
        .i_clk           (i_clk),
        .i_reset         (i_reset),
        .i_stall         (i_stall),
        .i_redirect      (i_redirect),
        .i_redirect_word (i_redirect_pc[PC_W-1:2]),
        .o_pc            (w_pc)
    );

    assign o_imem_addr = w_pc;

    // A redirect flushes IF/ID but keeps the old PC fields; the counter only moves on real loads.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_if_pc       <= '0;
            r_if_pc_plus4 <= PC_W'(PC_INC);
            r_if_instr    <= NOP_INSTR;
            r_if_valid    <= 1'b0;
            r_fetch_count <= '0;
        end else if (i_redirect) begin
            r_if_instr    <= NOP_INSTR;
            r_if_valid    <= 1'b0;
        end else if (!i_stall) begin
            r_if_pc       <= w_pc;
            r_if_pc_plus4 <= w_pc + PC_W'(PC_INC);
            r_if_instr    <= i_imem_instr;
            r_if_valid    <= 1'b1;
            if (r_fetch_count != '1) begin
                r_fetch_count <= r_fetch_count + 1'b1;
            end
        end
    end

`ifdef FETCH_MISALIGN_CHK_EN
    logic r_misalign_err;

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_misalign_err <= 1'b0;
        end else if (i_redirect && (i_redirect_pc[1:0] != 2'b00)) begin
            r_misalign_err <= 1'b1;
        end
    end

    assign o_misalign_err = r_misalign_err;
`else
    logic w_lowbits_unused;
    assign w_lowbits_unused = ^i_redirect_pc[1:0];
    assign o_misalign_err   = 1'b0;
`endif

    assign o_if_pc       = r_if_pc;
    assign o_if_pc_plus4 = r_if_pc_plus4;
    assign o_if_instr    = r_if_instr;
    assign o_if_valid    = r_if_valid;
    assign o_fetch_count = r_fetch_count;

endmodule

// File: tb/tb_fetch_stage.sv
// Self-checking bench for fetch_stage: directed scenarios plus random stall/redirect/reset traffic.
// Honors FETCH_MISALIGN_CHK_EN for the expected misalign_err behaviour.
module tb_fetch_stage;

    localparam int unsigned PC_W  = 8;
    localparam int unsigned CNT_W = 4;
`ifdef FETCH_MISALIGN_CHK_EN
    localparam bit CHK_EN = 1'b1;
`else
    localparam bit CHK_EN = 1'b0;
`endif

    logic             i_clk = 1'b0;
    logic             i_reset;
    logic             i_stall;
    logic             i_redirect;
    logic [PC_W-1:0]  i_redirect_pc;
    logic [PC_W-1:0]  o_imem_addr;
    logic [31:0]      w_imem_instr;
    logic [PC_W-1:0]  o_if_pc;
    logic [PC_W-1:0]  o_if_pc_plus4;
    logic [31:0]      o_if_instr;
    logic             o_if_valid;
    logic [CNT_W-1:0] o_fetch_count;
    logic             o_misalign_err;

    logic [31:0] mem [64];

    int n_checks = 0;
    int n_errors = 0;

    // Reference state, as plain integers
    int m_pc, m_if_pc, m_if_p4, m_cnt;
    logic [31:0] m_instr;
    bit m_valid, m_err;

    always #5 i_clk = ~i_clk;

    assign w_imem_instr = mem[o_imem_addr[7:2]];

    fetch_stage #(
        .PC_W     (PC_W),
        .RESET_PC (8'h00),
        .CNT_W    (CNT_W)
    ) dut (
        .i_clk          (i_clk),
        .i_reset        (i_reset),
        .i_stall        (i_stall),
        .i_redirect     (i_redirect),
        .i_redirect_pc  (i_redirect_pc),
        .o_imem_addr    (o_imem_addr),
        .i_imem_instr   (w_imem_instr),
        .o_if_pc        (o_if_pc),
        .o_if_pc_plus4  (o_if_pc_plus4),
        .o_if_instr     (o_if_instr),
        .o_if_valid     (o_if_valid),
        .o_fetch_count  (o_fetch_count),
        .o_misalign_err (o_misalign_err)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s t=%0t got=%h want=%h", tag, $time, obs, exp);
        end
    endtask

    // Apply inputs for one cycle, advance the model at the edge, compare everything just after.
    task automatic step(input bit rst, input bit stl, input bit rdr, input int rpc);
        i_reset       = rst;
        i_stall       = stl;
        i_redirect    = rdr;
        i_redirect_pc = PC_W'(rpc);
        @(posedge i_clk);
        if (rst) begin
            m_pc = 0; m_if_pc = 0; m_if_p4 = 4; m_instr = 32'h0000_0013;
            m_valid = 0; m_cnt = 0; m_err = 0;
        end else if (rdr) begin
            if (CHK_EN && (rpc % 4 != 0)) m_err = 1;
            m_pc    = rpc - (rpc % 4);
            m_valid = 0;
            m_instr = 32'h0000_0013;
        end else if (!stl) begin
            m_if_pc = m_pc;
            m_if_p4 = (m_pc + 4) % 256;
            m_instr = mem[m_pc / 4];
            m_valid = 1;
            if (m_cnt < (1 << CNT_W) - 1) m_cnt++;
            m_pc = (m_pc + 4) % 256;
        end
        #1;
        check("imem_addr",    32'(o_imem_addr),    32'(m_pc));
        check("if_pc",        32'(o_if_pc),        32'(m_if_pc));
        check("if_pc_plus4",  32'(o_if_pc_plus4),  32'(m_if_p4));
        check("if_instr",     o_if_instr,          m_instr);
        check("if_valid",     32'(o_if_valid),     32'(m_valid));
        check("fetch_count",  32'(o_fetch_count),  32'(m_cnt));
        check("misalign_err", 32'(o_misalign_err), 32'(m_err));
    endtask

    initial begin
        for (int i = 0; i < 64; i++) mem[i] = $urandom;
        mem[1] = 32'h0010_0093;
        m_pc = 0; m_if_pc = 0; m_if_p4 = 4; m_instr = 32'h0000_0013;
        m_valid = 0; m_cnt = 0; m_err = 0;

        // Reset for two cycles
        step(1, 0, 0, 0);
        step(1, 0, 0, 0);
        check("rst_addr", 32'(o_imem_addr), 32'h0);
        check("rst_instr", o_if_instr, 32'h0000_0013);

        // Free run: second edge holds the word at byte address 4
        step(0, 0, 0, 0);
        step(0, 0, 0, 0);
        check("run_if_pc", 32'(o_if_pc), 32'h04);
        check("run_instr", o_if_instr, 32'h0010_0093);
        check("run_p4", 32'(o_if_pc_plus4), 32'h08);

        // Reach pc=0x0C, stall three cycles, then release
        step(0, 0, 0, 0);
        for (int i = 0; i < 3; i++) begin
            step(0, 1, 0, 0);
            check("stall_addr", 32'(o_imem_addr), 32'h0C);
        end
        step(0, 0, 0, 0);
        check("release_if_pc", 32'(o_if_pc), 32'h0C);

        // Redirect under stall wins over the stall
        step(0, 1, 1, 8'h40);
        check("redir_addr", 32'(o_imem_addr), 32'h40);
        step(0, 0, 0, 0);
        check("redir_if_pc", 32'(o_if_pc), 32'h40);

        // Wrap from 0xFC to 0x00
        step(0, 0, 1, 8'hF8);
        step(0, 0, 0, 0);
        step(0, 0, 0, 0);
        check("wrap_addr", 32'(o_imem_addr), 32'h00);
        check("wrap_if_pc", 32'(o_if_pc), 32'hFC);
        check("wrap_p4", 32'(o_if_pc_plus4), 32'h00);

        // Misaligned redirect: low bits dropped, flag sticky until reset
        step(0, 0, 1, 8'h22);
        check("mis_addr", 32'(o_imem_addr), 32'h20);
        step(0, 0, 0, 0);
        step(0, 0, 1, 8'h10);
        check("mis_sticky", 32'(o_misalign_err), 32'(CHK_EN));
        step(1, 0, 1, 8'h33);

        // Random traffic; long enough to saturate the narrow counter
        for (int i = 0; i < 600; i++) begin
            step(($urandom_range(0, 99) == 0), ($urandom_range(0, 3) == 0),
                 ($urandom_range(0, 7) == 0), int'($urandom_range(0, 255)));
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
